// File: rtl/viterbi_seq_pkg.sv
// Shared definitions for the Viterbi link sequencer: FSM states, PRBS-7
// polynomial/seed and default pipeline dimensions.
package viterbi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_TAIL,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // x^7 + x^6 + 1: feedback taps on the two oldest bits of the history
    localparam logic [6:0] PRBS_TAPS = 7'b110_0000;
    localparam logic [6:0] PRBS_SEED = 7'h7F;

    localparam int LAT_DEFAULT  = 18;
    localparam int TAIL_DEFAULT = 2;

    function automatic logic prbs_bit(input logic [6:0] state);
        return ^(state & PRBS_TAPS);
    endfunction

    function automatic logic [6:0] prbs_step(input logic [6:0] state);
        return {state[5:0], prbs_bit(state)};
    endfunction

endpackage

// File: rtl/viterbi_ref_delay.sv
// Reference delay line: carries {payload_flag, encoder bit} LAT clocks so it
// lines up with the decoder output.
module viterbi_ref_delay #(
    parameter int LAT = 18,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_reg [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = stage_reg[LAT-1];

endmodule

// File: rtl/viterbi_link_sequencer.sv
// Frame sequencer for a Viterbi encoder/channel/decoder link: PRBS payload,
// zero tail, drain, error injection and bit-error counting.
// Optional build macro VITERBI_SEQ_BURST_EN: inject 2'b11 instead of 2'b01.
module viterbi_link_sequencer
    import viterbi_seq_pkg::*;
#(
    parameter int LAT  = LAT_DEFAULT,
    parameter int TAIL = TAIL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  frame_len_i,
    input  logic [3:0]  err_period_i,
    input  logic        dec_bit_i,
    output logic        enc_bit_o,
    output logic        enc_en_o,
    output logic [1:0]  err_mask_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] inj_ct_o
);

`ifdef VITERBI_SEQ_BURST_EN
    localparam logic [1:0] ERR_MASK = 2'b11;
`else
    localparam logic [1:0] ERR_MASK = 2'b01;
`endif

    localparam logic [8:0] TAIL_LAST = 9'(TAIL - 1);
    localparam logic [8:0] LAT_LAST  = 9'(LAT - 1);

    seq_state_t  state_reg, state_next;
    logic [8:0]  phase_ct_reg, phase_ct_next;
    logic [8:0]  len_reg;
    logic [3:0]  period_reg;
    logic [6:0]  prbs_reg;
    logic [15:0] sym_ct_reg;
    logic [15:0] bit_err_reg;
    logic [15:0] inj_reg;

    logic        launch;
    logic        payload;
    logic        enc_en;
    logic        enc_bit;
    logic        mask_hit;
    logic [15:0] low_mask;
    logic [1:0]  dly_out;

    always_comb begin
        state_next    = state_reg;
        phase_ct_next = phase_ct_reg + 9'd1;
        launch        = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                phase_ct_next = phase_ct_reg;
                if (start_i) begin
                    launch        = 1'b1;
                    state_next    = ST_RUN;
                    phase_ct_next = '0;
                end
            end
            ST_RUN: begin
                if (phase_ct_reg == len_reg - 9'd1) begin
                    state_next    = ST_TAIL;
                    phase_ct_next = '0;
                end
            end
            ST_TAIL: begin
                if (phase_ct_reg == TAIL_LAST) begin
                    state_next    = ST_DRAIN;
                    phase_ct_next = '0;
                end
            end
            ST_DRAIN: begin
                if (phase_ct_reg == LAT_LAST) begin
                    state_next    = ST_DONE;
                    phase_ct_next = '0;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                phase_ct_next = '0;
            end
        endcase
    end

    assign payload  = (state_reg == ST_RUN);
    assign enc_en   = payload || (state_reg == ST_TAIL);
    assign enc_bit  = payload && prbs_bit(prbs_reg);
    // Inject on every 2^P-th encoded symbol, i.e. when the low P bits are all ones
    assign low_mask = (16'd1 << period_reg) - 16'd1;
    assign mask_hit = enc_en && (period_reg != 4'd0) && ((sym_ct_reg & low_mask) == low_mask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            phase_ct_reg <= '0;
            len_reg      <= '0;
            period_reg   <= '0;
            prbs_reg     <= PRBS_SEED;
            sym_ct_reg   <= '0;
            bit_err_reg  <= '0;
            inj_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            phase_ct_reg <= phase_ct_next;
            if (launch) begin
                len_reg     <= (frame_len_i == 8'd0) ? 9'd256 : {1'b0, frame_len_i};
                period_reg  <= err_period_i;
                prbs_reg    <= PRBS_SEED;
                sym_ct_reg  <= '0;
                bit_err_reg <= '0;
                inj_reg     <= '0;
            end else begin
                if (payload) begin
                    prbs_reg <= prbs_step(prbs_reg);
                end
                if (enc_en) begin
                    sym_ct_reg <= sym_ct_reg + 16'd1;
                end
                if (mask_hit && (inj_reg != 16'hFFFF)) begin
                    inj_reg <= inj_reg + 16'd1;
                end
                if (busy_o && dly_out[1] && (dec_bit_i != dly_out[0]) && (bit_err_reg != 16'hFFFF)) begin
                    bit_err_reg <= bit_err_reg + 16'd1;
                end
            end
        end
    end

    viterbi_ref_delay #(
        .LAT (LAT),
        .W   (2)
    ) u_ref_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({payload, enc_bit}),
        .dout (dly_out)
    );

    assign enc_bit_o    = enc_bit;
    assign enc_en_o     = enc_en;
    assign err_mask_o   = mask_hit ? ERR_MASK : 2'b00;
    assign busy_o       = payload || (state_reg == ST_TAIL) || (state_reg == ST_DRAIN);
    assign done_o       = (state_reg == ST_DONE);
    assign bit_err_ct_o = bit_err_reg;
    assign inj_ct_o     = inj_reg;

endmodule

// File: tb/tb_viterbi_link_sequencer.sv
// Self-checking bench for viterbi_link_sequencer: directed table, mid-frame
// reset sequence and randomized frames against a recurrence-based model.
`timescale 1ns/1ps
module tb_viterbi_link_sequencer;

    localparam int LAT  = 18;
    localparam int TAIL = 2;
`ifdef VITERBI_SEQ_BURST_EN
    localparam logic [1:0] MASKV = 2'b11;
`else
    localparam logic [1:0] MASKV = 2'b01;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  frame_len_i;
    logic [3:0]  err_period_i;
    logic        dec_bit_i;
    logic        enc_bit_o;
    logic        enc_en_o;
    logic [1:0]  err_mask_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bit_err_ct_o;
    logic [15:0] inj_ct_o;

    int checks   = 0;
    int failures = 0;

    // PRBS-7 reference: s[n] = s[n-7] ^ s[n-6], with seven ones before n=0
    logic prbs_seq [0:299];

    typedef struct {
        int len8;
        int p;
        int mode;      // 0 ideal link, 1 inverted decoder, 2 random decoder
        int extra_at;  // cycle of a stray start pulse, -1 for none
        int exp_lat;
        int exp_inj;
        int exp_err_def;
        int exp_err_burst;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    viterbi_link_sequencer #(
        .LAT  (LAT),
        .TAIL (TAIL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .frame_len_i  (frame_len_i),
        .err_period_i (err_period_i),
        .dec_bit_i    (dec_bit_i),
        .enc_bit_o    (enc_bit_o),
        .enc_en_o     (enc_en_o),
        .err_mask_o   (err_mask_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bit_err_ct_o (bit_err_ct_o),
        .inj_ct_o     (inj_ct_o)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] mask_ref(input int k, input int n_enc, input int p);
        int period;
        period = 1 << p;
        if (k < n_enc && p != 0 && (k % period) == period - 1) return MASKV;
        return 2'b00;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_enc_bit"}, enc_bit_o, 0);
        check({tag, "_enc_en"}, enc_en_o, 0);
        check({tag, "_err_mask"}, err_mask_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_bit_err_ct"}, bit_err_ct_o, 0);
        check({tag, "_inj_ct"}, inj_ct_o, 0);
    endtask

    // Call just after a negedge; returns just after a negedge in DONE.
    task automatic run_frame(input int len8, input int p, input int mode, input int extra_at,
                             output int lat_obs, output int err_obs, output int inj_obs);
        int n, n_enc, total, exp_err, exp_inj, j;
        logic [1:0] m;
        logic d;
        n       = (len8 == 0) ? 256 : len8;
        n_enc   = n + TAIL;
        total   = n_enc + LAT;
        exp_err = 0;
        exp_inj = 0;
        lat_obs = -1;
        start_i      = 1'b1;
        frame_len_i  = len8[7:0];
        err_period_i = p[3:0];
        for (int c = 0; c <= total + 4; c++) begin
            @(negedge clk);
            start_i      = (c == extra_at);
            frame_len_i  = 8'($urandom);
            err_period_i = 4'($urandom);
            if (done_o) begin
                lat_obs = c;
                break;
            end
            if (c < total) begin
                m = mask_ref(c, n_enc, p);
                if (m != 2'b00) exp_inj++;
                check("busy", busy_o, 1);
                check("enc_en", enc_en_o, (c < n_enc) ? 1 : 0);
                check("enc_bit", enc_bit_o, (c < n) ? int'(prbs_seq[c]) : 0);
                check("err_mask", err_mask_o, m);
            end
            j = c - LAT;
            d = 1'($urandom);
            if (j >= 0 && j < n) begin
                case (mode)
                    0: d = prbs_seq[j] ^ (mask_ref(j, n_enc, p) == 2'b11);
                    1: d = ~prbs_seq[j];
                    default: d = 1'($urandom);
                endcase
                if (d != prbs_seq[j]) exp_err++;
            end
            dec_bit_i = d;
        end
        check("latency", lat_obs, total);
        check("bit_err_ct", bit_err_ct_o, exp_err);
        check("inj_ct", inj_ct_o, exp_inj);
        err_obs = bit_err_ct_o;
        inj_obs = inj_ct_o;
        for (int h = 0; h < 3; h++) begin
            dec_bit_i = 1'($urandom);
            @(negedge clk);
            check("hold_done", done_o, 1);
            check("hold_busy", busy_o, 0);
            check("hold_enc_en", enc_en_o, 0);
            check("hold_bit_err_ct", bit_err_ct_o, exp_err);
            check("hold_inj_ct", inj_ct_o, exp_inj);
        end
        $display("frame len=%0d p=%0d mode=%0d extra_at=%0d lat=%0d bit_err=%0d inj=%0d",
                 n, p, mode, extra_at, lat_obs, err_obs, inj_obs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hist [0:306];
        int lat_o, err_o, inj_o, n, total, extra;
        for (int i = 0; i < 7; i++) hist[i] = 1'b1;
        for (int i = 7; i < 307; i++) hist[i] = hist[i-7] ^ hist[i-6];
        for (int k = 0; k < 300; k++) prbs_seq[k] = hist[k+7];

        vecs[0] = '{100, 0, 0, -1, 120,  0,  0,  0};
        vecs[1] = '{  0, 4, 0, -1, 276, 16,  0, 16};
        vecs[2] = '{ 10, 1, 0, -1,  30,  6,  0,  5};
        vecs[3] = '{ 50, 0, 1, -1,  70,  0, 50, 50};
        vecs[4] = '{ 40, 0, 0, 40,  60,  0,  0,  0};
        vecs[5] = '{  1, 1, 1, -1,  21,  1,  1,  1};
        vecs[6] = '{ 20, 2, 1,  5,  40,  5, 20, 20};

        rst          = 1'b0;
        start_i      = 1'b0;
        frame_len_i  = 8'd0;
        err_period_i = 4'd0;
        dec_bit_i    = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done", done_o, 0);
        check("idle_busy", busy_o, 0);

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].len8, vecs[v].p, vecs[v].mode, vecs[v].extra_at, lat_o, err_o, inj_o);
            check("tbl_latency", lat_o, vecs[v].exp_lat);
            check("tbl_inj_ct", inj_o, vecs[v].exp_inj);
            check("tbl_bit_err_ct", err_o, (MASKV == 2'b11) ? vecs[v].exp_err_burst : vecs[v].exp_err_def);
        end

        // Reset in the middle of RUN, then confirm the PRBS restarts from the seed
        start_i      = 1'b1;
        frame_len_i  = 8'd100;
        err_period_i = 4'd2;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            dec_bit_i = 1'($urandom);
            check("pre_rst_enc_bit", enc_bit_o, prbs_seq[c]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        check_all_zero("midrst_next");
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle_busy", busy_o, 0);
            check("post_rst_idle_done", done_o, 0);
        end
        run_frame(100, 0, 0, -1, lat_o, err_o, inj_o);

        for (int r = 0; r < 8; r++) begin
            n     = $urandom_range(1, 80);
            total = n + TAIL + LAT;
            extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, total - 1)) : -1;
            run_frame(n, $urandom_range(0, 5), $urandom_range(0, 2), extra, lat_o, err_o, inj_o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/viterbi_link_sequencer.md
VITERBI_LINK_SEQUENCER -- requirements
Module: viterbi_link_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 18: encoder-input to decoder-output latency in clocks; range 1..63.
REQ-002 SHALL have parameter TAIL, default 2: number of zero flush bits (K-1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  one-cycle pulse; launches a frame; ignored unless in IDLE or DONE.
REQ-006 frame_len_i  input  8  payload bits per frame; 0 is treated as 256.
REQ-007 err_period_i  input  4  log2 injection period P; 0 disables injection.
REQ-008 dec_bit_i  input  1  decoder output bit.
REQ-009 enc_bit_o  output  1  encoder data input.
REQ-010 enc_en_o  output  1  encoder enable.
REQ-011 err_mask_o  output  2  XOR mask applied by the channel to the encoder symbol.
REQ-012 busy_o  output  1  high in RUN, TAIL and DRAIN.
REQ-013 done_o  output  1  high in DONE.
REQ-014 bit_err_ct_o  output  16  saturating count of decoded-bit mismatches.
REQ-015 inj_ct_o  output  16  saturating count of injected error symbols.

Function
REQ-016 SHALL implement the FSM IDLE->RUN->TAIL->DRAIN->DONE; start_i in IDLE or DONE -> RUN.
REQ-017 RUN SHALL last exactly frame_len cycles, with enc_en_o=1 and enc_bit_o = the PRBS-7 output (x^7+x^6+1, seeded 7'h7F on every start).
REQ-018 TAIL SHALL last TAIL cycles with enc_en_o=1 and enc_bit_o=0; then DRAIN.
REQ-019 DRAIN SHALL last LAT cycles with enc_en_o=0; then DONE.
REQ-020 A symbol counter SHALL clear on start and increment each cycle enc_en_o=1.
REQ-021 err_mask_o SHALL be nonzero only when enc_en_o=1, P!=0, and the counter's low P bits are all ones; the mask applies to the symbol registered with that enc_en_o cycle.
REQ-022 Each nonzero err_mask_o cycle SHALL increment inj_ct_o.
REQ-023 A LAT-deep delay line SHALL carry {payload_flag, enc_bit_o}, with payload_flag=1 only in RUN.
REQ-024 dec_bit_i SHALL be compared only when the delayed payload_flag=1; a mismatch increments bit_err_ct_o.
REQ-025 Both counters SHALL saturate at 16'hFFFF, clear on start, and hold their values in DONE.
REQ-026 start_i while busy_o=1 SHALL be ignored; the running frame is unaffected.
REQ-027 err_period_i and frame_len_i SHALL be sampled at start; later changes have no effect on the current frame.
REQ-028 When start_i occurs in DONE, RUN SHALL begin on the next cycle and done_o SHALL fall on that same cycle.

Reset
REQ-029 rst low SHALL force IDLE, clear the counters, clear the delay line, reseed the PRBS, and drive all outputs to 0, including mid-frame.
REQ-030 After rst rises, the block SHALL remain in IDLE until start_i.

Configuration
REQ-031 With VITERBI_SEQ_BURST_EN defined, err_mask_o SHALL be 2'b11 (both symbol bits corrupted).
REQ-032 Without VITERBI_SEQ_BURST_EN, err_mask_o SHALL be 2'b01.

Structure
REQ-033 Package viterbi_seq_pkg SHALL hold the FSM state enum, the PRBS polynomial and seed, and the default LAT and TAIL values.
REQ-034 The delay line SHALL be a sub-module, viterbi_ref_delay, parameterised by LAT, with width 2.

Verification
REQ-035 The bench SHALL cover these scenarios:
- frame_len=100, P=0, ideal link -> done_o after 100+2+18 cycles; bit_err_ct=0; inj_ct=0.
- frame_len=256 (value 8'd0), P=4 -> inj_ct=16; with the decoder attached, bit_err_ct=0.
- P=1 with VITERBI_SEQ_BURST_EN -> err_mask_o=2'b11 on every second enc_en cycle; bit_err_ct>0.
- dec_bit_i forced inverted, frame_len=50 -> bit_err_ct=50; tail bits are not counted.
- rst pulsed at RUN cycle 30 -> all outputs are 0 next cycle; a new start reproduces the identical PRBS sequence.
- start_i pulsed in TAIL -> ignored; done_o timing is unchanged.
